// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI transaction sequencer.
//   ADDR_W / DATA_W : slave address and data widths
//   spi_cmd_t       : one queued command {rd_wr, addr, wdata}
//   seq_state_t     : sequencer FSM states
package spi_seq_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              rd_wr;  // 1 = read, 0 = write
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } spi_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO for the SPI sequencer.
//   mclk, reset : clock, asynchronous active-high reset
//   push        : write push_data (ignored when full)
//   push_data   : command to store
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : head entry, valid whenever empty is low
//   full, empty : occupancy flags, derived from registered state only
module spi_cmd_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     mclk,
  input  logic     reset,
  input  logic     push,
  input  spi_cmd_t push_data,
  input  logic     pop,
  output spi_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  spi_cmd_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge mclk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Command front-end for the SPI master. Commands are queued in a FIFO and
// replayed one at a time as a framed transaction: start is held high for
// XFER_CYCLES with master_* stable, then low for at least GAP_CYCLES. Each
// command yields exactly one response, in command order.
//
// Handshakes: a transfer happens on a rising mclk edge where valid and ready
// are both high. The producer keeps valid and its payload stable until that
// edge; ready may be high or low independently of valid. On the response
// port the payload stays stable while rsp_valid is high and rsp_ready low.
//
// Ports:
//   mclk, reset        : clock, asynchronous active-high reset
//   cmd_valid/ready    : command handshake; cmd_ready = FIFO not full
//   cmd_rd_wr/addr/wdata : command payload
//   rsp_valid/ready    : response handshake
//   rsp_rd_wr/addr/rdata : response payload (rdata 0 for writes)
//   busy               : FSM not idle or commands still queued
//   start, master_*    : frame outputs to the SPI master
//   master_in_data     : read data from the SPI master
//   dbg_state          : current FSM state (seq_state_t encoding)
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int XFER_CYCLES = 18,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rd_wr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              start,
  output logic              master_rd_wr,
  output logic [ADDR_W-1:0] master_address,
  output logic [DATA_W-1:0] master_out_data,
  input  logic [DATA_W-1:0] master_in_data,
  output logic [1:0]        dbg_state
);

  localparam int XW = $clog2(XFER_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  seq_state_t     state;
  logic [XW-1:0]  xcnt;
  logic [GW-1:0]  gcnt;

  spi_cmd_t       push_cmd;
  spi_cmd_t       head_cmd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           launch;

  assign push_cmd = '{rd_wr: cmd_rd_wr, addr: cmd_addr, wdata: cmd_wdata};

  // A pending response blocks the next launch so it can never be overwritten.
  assign launch = (state == IDLE) && !fifo_empty && !rsp_valid;

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .mclk      (mclk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (launch),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign dbg_state = state;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      xcnt            <= '0;
      gcnt            <= '0;
      start           <= 1'b0;
      master_rd_wr    <= 1'b0;
      master_address  <= '0;
      master_out_data <= '0;
      rsp_valid       <= 1'b0;
      rsp_rd_wr       <= 1'b0;
      rsp_addr        <= '0;
      rsp_rdata       <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (launch) begin
            master_rd_wr    <= head_cmd.rd_wr;
            master_address  <= head_cmd.addr;
            master_out_data <= head_cmd.wdata;
            start           <= 1'b1;
            xcnt            <= '0;
            state           <= XFER;
          end
        end

        XFER: begin
          if (xcnt == XW'(XFER_CYCLES - 1)) begin
            // The master's last bit has been sampled; capture read data now.
            start     <= 1'b0;
            rsp_rd_wr <= master_rd_wr;
            rsp_addr  <= master_address;
            rsp_rdata <= master_rd_wr ? master_in_data : '0;
            rsp_valid <= 1'b1;
            gcnt      <= '0;
            state     <= GAP;
          end else begin
            xcnt <= xcnt + XW'(1);
          end
        end

        GAP: begin
          if (gcnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end

        default: begin
          state <= IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
module tb_spi_txn_sequencer;

  localparam int XFER   = 18;
  localparam int GAP    = 2;
  localparam int PERIOD = 1 + XFER + GAP;

  logic       mclk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd_wr;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_rd_wr;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       start;
  logic       master_rd_wr;
  logic [6:0] master_address;
  logic [7:0] master_out_data;
  logic [7:0] master_in_data;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard: frames expected on the master side, responses expected back.
  logic [15:0] mst_q[$];
  logic [15:0] exp_q[$];
  int          rise_q[$];

  bit          rand_rdy     = 0;
  bit          stub_fixed_en = 0;
  logic [7:0]  stub_fixed   = 8'h00;

  spi_txn_sequencer dut (
    .mclk            (mclk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_rd_wr       (cmd_rd_wr),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rd_wr       (rsp_rd_wr),
    .rsp_addr        (rsp_addr),
    .rsp_rdata       (rsp_rdata),
    .busy            (busy),
    .start           (start),
    .master_rd_wr    (master_rd_wr),
    .master_address  (master_address),
    .master_out_data (master_out_data),
    .master_in_data  (master_in_data),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Slave stub: read data is a fixed function of the addressed slave.
  assign master_in_data = stub_fixed_en ? stub_fixed : ({master_address, 1'b1} ^ 8'h3C);

  function automatic logic [7:0] slave_model(input logic [6:0] a);
    return stub_fixed_en ? stub_fixed : ({a, 1'b1} ^ 8'h3C);
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge mclk);
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_cmd(input logic rd, input logic [6:0] a, input logic [7:0] wd,
                          output int waits);
    cmd_valid = 1'b1;
    cmd_rd_wr = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    waits = 0;
    while (!cmd_ready && waits < 300) begin
      tick();
      waits++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1 within 300 cycles", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      tick();
      mst_q.push_back({rd, a, wd});
      exp_q.push_back({rd, a, rd ? slave_model(a) : 8'h00});
    end
  endtask

  task automatic send_rand(output int waits);
    send_cmd(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
             8'($urandom_range(0, 255)), waits);
  endtask

  task automatic wait_drain(input int bound, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    ok = (exp_q.size() == 0);
  endtask

  // Bus and response monitor: frame length, gap length, frame contents,
  // response order and response stability.
  task automatic monitor_loop();
    logic        prev_start = 1'b0;
    int          hi_run = 0;
    int          lo_run = 0;
    bit          have_frame = 0;
    bit          held = 0;
    logic [15:0] cur = '0;
    logic [15:0] held_val = '0;
    logic [15:0] obs;
    logic [15:0] exp;
    forever begin
      @(negedge mclk);
      cyc++;
      if (reset) begin
        prev_start = 1'b0;
        hi_run = 0;
        lo_run = 0;
        have_frame = 0;
        held = 0;
        mst_q.delete();
        exp_q.delete();
      end else begin
        if (start) begin
          if (!prev_start) begin
            rise_q.push_back(cyc);
            if (have_frame) begin
              checks++;
              if (lo_run < GAP) begin
                failures++;
                $display("FAIL gap_len: got %0d cycles low, required >= %0d", lo_run, GAP);
              end
            end
            checks++;
            if (mst_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_start: start rose at cycle %0d with no command queued", cyc);
            end else begin
              cur = mst_q.pop_front();
            end
            hi_run = 0;
          end
          hi_run++;
          obs = {master_rd_wr, master_address, master_out_data};
          checks++;
          if (obs !== cur) begin
            failures++;
            $display("FAIL frame_fields: got %h required %h", obs, cur);
          end
        end else begin
          if (prev_start) begin
            checks++;
            if (hi_run != XFER) begin
              failures++;
              $display("FAIL frame_len: got %0d cycles high, required %0d", hi_run, XFER);
            end
            checks++;
            if (rsp_valid !== 1'b1) begin
              failures++;
              $display("FAIL rsp_at_frame_end: rsp_valid=%b required 1", rsp_valid);
            end
            have_frame = 1;
            lo_run = 0;
          end
          lo_run++;
        end
        prev_start = start;

        obs = {rsp_rd_wr, rsp_addr, rsp_rdata};
        if (rsp_valid === 1'b1) begin
          if (held) begin
            checks++;
            if (obs !== held_val) begin
              failures++;
              $display("FAIL rsp_stable: got %h required %h", obs, held_val);
            end
          end
          if (rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_rsp: got %h with nothing outstanding", obs);
            end else begin
              exp = exp_q.pop_front();
              if (obs !== exp) begin
                failures++;
                $display("FAIL rsp_data: got %h required %h", obs, exp);
              end
            end
            held = 0;
          end else begin
            held = 1;
            held_val = obs;
          end
        end else begin
          if (held) begin
            checks++;
            failures++;
            $display("FAIL rsp_dropped: rsp_valid=%b required 1 until consumed", rsp_valid);
          end
          held = 0;
        end
      end
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b required 0", start); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (master_address !== 7'h00) begin failures++; $display("FAIL reset_master_address: got %h required 00", master_address); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int w;
    int n = 0;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 7'h12, 8'h3C, w);
    cmd_valid = 1'b0;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL write_latency_pre: start=%b required 0", start); end
    tick();
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL write_latency_rise: start=%b required 1", start); end
    checks++; if (master_address !== 7'h12) begin failures++; $display("FAIL write_address: got %h required 12", master_address); end
    checks++; if (master_out_data !== 8'h3C) begin failures++; $display("FAIL write_out_data: got %h required 3c", master_out_data); end
    while (!rsp_valid && n < 40) begin tick(); n++; end
    checks++;
    if ({rsp_valid, rsp_rd_wr, rsp_addr, rsp_rdata} !== {1'b1, 1'b0, 7'h12, 8'h00}) begin
      failures++;
      $display("FAIL write_rsp: got v=%b rw=%b a=%h d=%h required v=1 rw=0 a=12 d=00",
               rsp_valid, rsp_rd_wr, rsp_addr, rsp_rdata);
    end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL write_start_after: got %b required 0", start); end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL write_rsp_clear: got %b required 0", rsp_valid); end
    repeat (3) tick();
  endtask

  task automatic test_single_read();
    int w;
    int n = 0;
    rsp_ready = 1'b0;
    stub_fixed_en = 1;
    stub_fixed = 8'hA5;
    send_cmd(1'b1, 7'h55, 8'($urandom_range(0, 255)), w);
    cmd_valid = 1'b0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    checks++;
    if ({rsp_valid, rsp_rd_wr, rsp_addr, rsp_rdata} !== {1'b1, 1'b1, 7'h55, 8'hA5}) begin
      failures++;
      $display("FAIL read_rsp: got v=%b rw=%b a=%h d=%h required v=1 rw=1 a=55 d=a5",
               rsp_valid, rsp_rd_wr, rsp_addr, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    stub_fixed_en = 0;
    repeat (3) tick();
  endtask

  task automatic test_burst();
    int w;
    int tot = 0;
    int base;
    bit ok;
    rsp_ready = 1'b1;
    base = rise_q.size();
    for (int i = 0; i < 5; i++) begin
      send_rand(w);
      tot += w;
    end
    cmd_valid = 1'b0;
    checks++; if (tot != 0) begin failures++; $display("FAIL burst_accept_stall: got %0d stall cycles required 0", tot); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL burst_full: cmd_ready=%b required 0", cmd_ready); end
    wait_drain(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_drain: %0d responses outstanding required 0", exp_q.size()); end
    checks++;
    if (rise_q.size() - base != 5) begin
      failures++;
      $display("FAIL burst_frames: got %0d frames required 5", rise_q.size() - base);
    end else begin
      for (int i = base + 1; i < base + 5; i++) begin
        checks++;
        if (rise_q[i] - rise_q[i-1] != PERIOD) begin
          failures++;
          $display("FAIL burst_period: got %0d cycles required %0d", rise_q[i] - rise_q[i-1], PERIOD);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    int w;
    int base;
    bit ok;
    rsp_ready = 1'b0;
    base = rise_q.size();
    send_rand(w);
    send_rand(w);
    cmd_valid = 1'b0;
    repeat (40) tick();
    checks++; if (rise_q.size() - base != 1) begin failures++; $display("FAIL bp_frames: got %0d frames required 1", rise_q.size() - base); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_held: rsp_valid=%b required 1", rsp_valid); end
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL bp_start_low: start=%b required 0", start); end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || start !== 1'b0) begin failures++; $display("FAIL bp_release: rsp_valid=%b start=%b required 0 0", rsp_valid, start); end
    tick();
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL bp_second_start: start=%b required 1", start); end
    wait_drain(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_drain: %0d responses outstanding required 0", exp_q.size()); end
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    int w;
    bit ok;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_rand(w);
      cmd_valid = 1'b0;
      wait_drain(100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wrap_drain: cmd %0d outstanding=%0d required 0", i, exp_q.size()); end
      repeat (3) tick();
      checks++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL wrap_idle: cmd %0d busy=%b state=%0d required 0 0", i, busy, dbg_state); end
      repeat ($urandom_range(0, 5)) tick();
    end
  endtask

  task automatic test_random();
    int w;
    bit ok;
    rand_rdy = 1;
    for (int i = 0; i < 24; i++) begin
      send_rand(w);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    cmd_valid = 1'b0;
    wait_drain(3000, ok);
    rand_rdy = 0;
    rsp_ready = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL random_drain: %0d responses outstanding required 0", exp_q.size()); end
    repeat (4) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL random_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid_xfer();
    int w;
    int n = 0;
    bit saw = 0;
    rsp_ready = 1'b1;
    send_rand(w);
    send_rand(w);
    cmd_valid = 1'b0;
    while (!start && n < 50) begin tick(); n++; end
    repeat (7) tick();
    #1;
    reset = 1'b1;
    #1;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL midreset_start: got %b required 0", start); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midreset_fifo: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy); end
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL midreset_state: rsp_valid=%b state=%0d required 0 0", rsp_valid, dbg_state); end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid || start || busy) saw = 1;
    end
    checks++; if (saw) begin failures++; $display("FAIL midreset_quiet: activity=%b required 0 after reset", saw); end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd_wr = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single_write();
    test_single_read();
    test_burst();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_mid_xfer();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
